// File: rtl/seq_sorter.sv
// Serial-in / serial-out frame sorter: loads DEPTH words, sorts them in place by
// odd-even transposition (one phase per clock), then streams the sorted frame out.
module seq_sorter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             desc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {S_LOAD, S_SORT, S_OUT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]    ph_q, ph_d;
    logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
    logic             mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    assign in_ready  = (state_q == S_LOAD) && !rst;
    assign busy      = (state_q != S_LOAD);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        ph_d     = ph_q;
        rd_cnt_d = rd_cnt_q;
        mode_d   = mode_q;
        data_d   = data_q;

        case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    data_d[wr_cnt_q[IW-1:0]] = in_data;
                    if (wr_cnt_q == '0) begin
                        mode_d = desc;
                    end
                    if (wr_cnt_q == LAST) begin
                        wr_cnt_d = '0;
                        ph_d     = '0;
                        state_d  = S_SORT;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            S_SORT: begin
                // Pairs start at even indices on even phases, odd indices on odd phases.
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    if (i[0] == ph_q[0]) begin
                        if (mode_q ? (data_q[i] < data_q[i+1]) : (data_q[i] > data_q[i+1])) begin
                            data_d[i]   = data_q[i+1];
                            data_d[i+1] = data_q[i];
                        end
                    end
                end
                if (ph_q == LAST) begin
                    rd_cnt_d = '0;
                    state_d  = S_OUT;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (rd_cnt_q == LAST) begin
                        rd_cnt_d = '0;
                        state_d  = S_LOAD;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase

        // Output registers look ahead at the post-update array so the first word is
        // already valid in the cycle the block enters OUT.
        out_valid_d = (state_d == S_OUT);
        out_data_d  = out_valid_d ? data_d[rd_cnt_d[IW-1:0]] : '0;
        out_last_d  = out_valid_d && (rd_cnt_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            wr_cnt_q    <= '0;
            ph_q        <= '0;
            rd_cnt_q    <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            ph_q        <= ph_d;
            rd_cnt_q    <= rd_cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: tb/tb_seq_sorter.sv
// Bench for seq_sorter: table-driven frames through a scoreboard, plus hand-written
// backpressure, mid-sort reset and DEPTH=5/WIDTH=12 sequences.
module tb_seq_sorter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, desc, out_valid, out_ready, out_last, busy;
    logic [7:0]  in_data, out_data;

    logic        b_in_valid, b_in_ready, b_desc, b_out_valid, b_out_ready, b_out_last, b_busy;
    logic [11:0] b_in_data, b_out_data;

    always #5 clk = ~clk;

    seq_sorter #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .desc(desc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    seq_sorter #(.WIDTH(12), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .desc(b_desc), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .busy(b_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;
    exp_t sbq[$];

    typedef struct packed {
        logic [3:0][7:0] in_w;
        logic            dsc;
        logic            flip;
        logic [3:0][7:0] exp_w;
    } vec_t;
    vec_t vecs[4];

    function automatic logic [3:0][7:0] mk(input logic [7:0] w0, w1, w2, w3);
        logic [3:0][7:0] r;
        r[0] = w0; r[1] = w1; r[2] = w2; r[3] = w3;
        return r;
    endfunction

    // Output monitor: scoreboard pop, stall stability, in_ready after final word.
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;
    bit         last_seen = 0;
    int         acc_cnt = 0;
    exp_t       e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            last_seen  = 0;
        end else begin
            if (last_seen) begin
                check("in_ready_after_last", in_ready, 1);
                last_seen = 0;
            end
            if (prev_stall) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_data", out_data, prev_data);
                check("stall_hold_last", out_last, prev_last);
            end
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid) check("busy_in_out", busy, 1);
            if (out_valid && out_ready) begin
                check("spurious_out", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_last", out_last, e.last);
                end
                last_seen = out_last;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    bit bp = 0;
    int k = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            k++;
            out_ready = bp ? (k % 3 == 0) : 1'b1;
        end
    end

    task automatic send_frame(input vec_t v, input bit hold, input bit push, input bit chk_lat);
        int n;
        bit acc;
        if (push)
            for (int i = 0; i < 4; i++) sbq.push_back({v.exp_w[i], i == 3});
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v.in_w[i];
            desc     = (v.flip && i > 0) ? ~v.dsc : v.dsc;
            acc = 0;
            n   = 0;
            while (!acc && n < 100) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!acc) check("in_accept_timeout", 0, 1);
        end
        if (hold) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            desc     = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        if (chk_lat) begin
            n = 0;
            while (out_valid !== 1'b1 && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("latency_edges", n, 4);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) check("drain_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int a0, n, idx;
        logic [11:0] b_in [5];
        logic [11:0] b_exp [5];

        vecs[0] = '{in_w: mk(8'h05, 8'h03, 8'h09, 8'h01), dsc: 0, flip: 0, exp_w: mk(8'h01, 8'h03, 8'h05, 8'h09)};
        vecs[1] = '{in_w: mk(8'h05, 8'h03, 8'h09, 8'h01), dsc: 1, flip: 1, exp_w: mk(8'h09, 8'h05, 8'h03, 8'h01)};
        vecs[2] = '{in_w: mk(8'hFF, 8'h80, 8'h7F, 8'h00), dsc: 0, flip: 0, exp_w: mk(8'h00, 8'h7F, 8'h80, 8'hFF)};
        vecs[3] = '{in_w: mk(8'h02, 8'h02, 8'h01, 8'h02), dsc: 0, flip: 0, exp_w: mk(8'h01, 8'h02, 8'h02, 8'h02)};

        rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; desc = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_desc = 1'b0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            send_frame(vecs[i], 0, 1, i == 0);
            wait_drain();
        end

        // Backpressure with in_valid held high through SORT and OUT.
        bp = 1;
        a0 = acc_cnt;
        v  = '{in_w: mk(8'h30, 8'h10, 8'h40, 8'h20), dsc: 0, flip: 0, exp_w: mk(8'h10, 8'h20, 8'h30, 8'h40)};
        send_frame(v, 1, 1, 0);
        wait_drain();
        check("bp_accept_count", acc_cnt - a0, 4);
        bp = 0;

        // Abort a frame at ph=2, then load a fresh one.
        v = '{in_w: mk(8'h10, 8'h20, 8'h30, 8'h40), dsc: 1, flip: 0, exp_w: '0};
        send_frame(v, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready_in_rst", in_ready, 0);
        rst = 1'b0;
        #1;
        check("abort_in_ready_after", in_ready, 1);
        v = '{in_w: mk(8'h04, 8'h03, 8'h02, 8'h01), dsc: 0, flip: 0, exp_w: mk(8'h01, 8'h02, 8'h03, 8'h04)};
        send_frame(v, 0, 1, 0);
        wait_drain();

        // DEPTH=5, WIDTH=12 instance.
        b_in[0] = 12'h800; b_in[1] = 12'h001; b_in[2] = 12'hFFF; b_in[3] = 12'h400; b_in[4] = 12'h001;
        b_exp[0] = 12'h001; b_exp[1] = 12'h001; b_exp[2] = 12'h400; b_exp[3] = 12'h800; b_exp[4] = 12'hFFF;
        for (int i = 0; i < 5; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = b_in[i];
            n = 0;
            do begin
                @(negedge clk);
                idx = int'(b_in_ready);
                @(posedge clk);
                #1;
                n++;
            end while (idx == 0 && n < 100);
            if (idx == 0) check("d5_accept_timeout", 0, 1);
        end
        b_in_valid = 1'b0;
        idx = 0;
        n   = 0;
        while (idx < 5 && n < 100) begin
            @(negedge clk);
            if (b_out_valid && b_out_ready) begin
                check("d5_out_data", b_out_data, b_exp[idx]);
                check("d5_out_last", b_out_last, idx == 4);
                idx++;
            end
            n++;
        end
        check("d5_word_count", idx, 5);

        repeat (3) @(posedge clk);
        check("sb_empty_at_end", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
